// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement controller.
// Holds the controller state encoding and default field widths.
package tdc_pkg;

    localparam int unsigned DEF_COARSE_W = 16;
    localparam int unsigned DEF_FINE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } tdc_state_e;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Coarse cycle counter with clear/enable and a registered terminal flag.
// o_term is high in the cycle where o_count == TIMEOUT-1.
module tdc_coarse_counter
    import tdc_pkg::*;
#(
    parameter int unsigned COARSE_W = DEF_COARSE_W,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_enable,
    output logic [COARSE_W-1:0] o_count,
    output logic                o_term
);

    localparam logic [COARSE_W-1:0] LP_TERM = COARSE_W'(TIMEOUT - 1);

    logic [COARSE_W-1:0] r_count;
    logic [COARSE_W-1:0] w_count_inc;
    logic                r_term;

    assign w_count_inc = r_count + COARSE_W'(1);

    // Flag is computed from the next count so it lines up with the count itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_term  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_term  <= (LP_TERM == '0);
        end else if (i_enable) begin
            r_count <= w_count_inc;
            r_term  <= (w_count_inc == LP_TERM);
        end
    end

    assign o_count = r_count;
    assign o_term  = r_term;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Start/stop time-interval measurement sequencer for the TDC front end.
// Optional macro TDC_HIT_STATS_EN adds saturating result statistics ports.
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int unsigned COARSE_W = DEF_COARSE_W,
    parameter int unsigned FINE_W   = DEF_FINE_W,
    parameter int unsigned TIMEOUT  = 1000
`ifdef TDC_HIT_STATS_EN
    ,
    parameter int unsigned STAT_W   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                start_valid,
    input  logic [FINE_W-1:0]   start_fine,
    input  logic                stop_valid,
    input  logic [FINE_W-1:0]   stop_fine,
    output logic                hit_gate,
    output logic                busy,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [COARSE_W-1:0] m_coarse,
    output logic [FINE_W-1:0]   m_start_fine,
    output logic [FINE_W-1:0]   m_stop_fine,
    output logic                m_timeout
`ifdef TDC_HIT_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_meas,
    output logic [STAT_W-1:0]   stat_timeouts
`endif
);

    tdc_state_e          r_state;
    tdc_state_e          w_next;

    logic [FINE_W-1:0]   r_start_fine;
    logic [COARSE_W-1:0] r_m_coarse;
    logic [FINE_W-1:0]   r_m_start_fine;
    logic [FINE_W-1:0]   r_m_stop_fine;
    logic                r_m_timeout;

    logic                w_clear;
    logic                w_enable;
    logic                w_cap;
    logic [COARSE_W-1:0] w_cap_coarse;
    logic [FINE_W-1:0]   w_cap_start;
    logic [FINE_W-1:0]   w_cap_stop;
    logic                w_cap_to;
    logic [COARSE_W-1:0] w_count;
    logic                w_term;
    logic                w_hs;

    tdc_coarse_counter #(
        .COARSE_W (COARSE_W),
        .TIMEOUT  (TIMEOUT)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_count  (w_count),
        .o_term   (w_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_clear      = 1'b0;
        w_enable     = 1'b0;
        w_cap        = 1'b0;
        w_cap_coarse = '0;
        w_cap_start  = r_start_fine;
        w_cap_stop   = '0;
        w_cap_to     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (arm) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (start_valid && stop_valid) begin
                    w_next      = ST_HOLD;
                    w_cap       = 1'b1;
                    w_cap_start = start_fine;
                    w_cap_stop  = stop_fine;
                end else if (start_valid) begin
                    w_next  = ST_RUN;
                    w_clear = 1'b1;
                end
            end
            ST_RUN: begin
                w_enable = 1'b1;
                // Count lags elapsed cycles by one; a stop on the terminal cycle wins.
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (stop_valid) begin
                    w_next       = ST_HOLD;
                    w_cap        = 1'b1;
                    w_cap_coarse = w_count + COARSE_W'(1);
                    w_cap_stop   = stop_fine;
                end else if (w_term) begin
                    w_next       = ST_HOLD;
                    w_cap        = 1'b1;
                    w_cap_coarse = COARSE_W'(TIMEOUT);
                    w_cap_to     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (m_ready) w_next = arm ? ST_ARMED : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_fine   <= '0;
            r_m_coarse     <= '0;
            r_m_start_fine <= '0;
            r_m_stop_fine  <= '0;
            r_m_timeout    <= 1'b0;
        end else begin
            if (w_clear) r_start_fine <= start_fine;
            if (w_cap) begin
                r_m_coarse     <= w_cap_coarse;
                r_m_start_fine <= w_cap_start;
                r_m_stop_fine  <= w_cap_stop;
                r_m_timeout    <= w_cap_to;
            end
        end
    end

    assign hit_gate     = (r_state == ST_ARMED) || (r_state == ST_RUN);
    assign busy         = (r_state != ST_IDLE);
    assign m_valid      = (r_state == ST_HOLD);
    assign m_coarse     = r_m_coarse;
    assign m_start_fine = r_m_start_fine;
    assign m_stop_fine  = r_m_stop_fine;
    assign m_timeout    = r_m_timeout;
    assign w_hs         = m_valid && m_ready;

`ifdef TDC_HIT_STATS_EN
    logic [STAT_W-1:0] r_stat_meas;
    logic [STAT_W-1:0] r_stat_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_meas <= '0;
            r_stat_to   <= '0;
        end else if (w_hs) begin
            if (r_m_timeout) begin
                if (r_stat_to != '1) r_stat_to <= r_stat_to + STAT_W'(1);
            end else begin
                if (r_stat_meas != '1) r_stat_meas <= r_stat_meas + STAT_W'(1);
            end
        end
    end

    assign stat_meas     = r_stat_meas;
    assign stat_timeouts = r_stat_to;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed self-checking bench for tdc_meas_ctrl (default parameters).
module tb_tdc_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        start_valid = 1'b0;
    logic [7:0]  start_fine = 8'h00;
    logic        stop_valid = 1'b0;
    logic [7:0]  stop_fine = 8'h00;
    logic        m_ready = 1'b0;
    logic        hit_gate;
    logic        busy;
    logic        m_valid;
    logic [15:0] m_coarse;
    logic [7:0]  m_start_fine;
    logic [7:0]  m_stop_fine;
    logic        m_timeout;
`ifdef TDC_HIT_STATS_EN
    logic [15:0] stat_meas;
    logic [15:0] stat_timeouts;
`endif

    int checks = 0;
    int failures = 0;

    tdc_meas_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .start_valid  (start_valid),
        .start_fine   (start_fine),
        .stop_valid   (stop_valid),
        .stop_fine    (stop_fine),
        .hit_gate     (hit_gate),
        .busy         (busy),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_coarse     (m_coarse),
        .m_start_fine (m_start_fine),
        .m_stop_fine  (m_stop_fine),
        .m_timeout    (m_timeout)
`ifdef TDC_HIT_STATS_EN
        ,
        .stat_meas    (stat_meas),
        .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm_start(input logic [7:0] sf);
        arm = 1'b1;
        tick;
        arm = 1'b0;
        start_valid = 1'b1;
        start_fine = sf;
        tick;
        start_valid = 1'b0;
        start_fine = 8'h00;
    endtask

    task automatic do_handshake;
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++;
        if ({hit_gate, busy, m_valid, m_timeout} !== 4'b0 || m_coarse !== 16'd0
            || m_start_fine !== 8'd0 || m_stop_fine !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: gate=%b busy=%b valid=%b to=%b coarse=%0d sf=%h pf=%h required all zero",
                     hit_gate, busy, m_valid, m_timeout, m_coarse, m_start_fine, m_stop_fine);
        end
        rst_n = 1'b1;
        tick;
        do_arm_start(8'h33);
        repeat (5) tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hit_gate, busy, m_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_run: gate/busy/valid=%b required 000", {hit_gate, busy, m_valid});
        end
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        arm = 1'b1;
        tick;
        arm = 1'b0;
        checks++;
        if ({hit_gate, busy, m_valid} !== 3'b110) begin
            failures++;
            $display("FAIL reset_rearm: gate/busy/valid=%b required 110", {hit_gate, busy, m_valid});
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_armed: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic;
        do_arm_start(8'h12);
        repeat (36) tick;
        checks++;
        if (m_valid !== 1'b0 || hit_gate !== 1'b1) begin
            failures++;
            $display("FAIL basic_running: valid=%b gate=%b required 0 1", m_valid, hit_gate);
        end
        stop_valid = 1'b1;
        stop_fine = 8'hA5;
        tick;
        stop_valid = 1'b0;
        stop_fine = 8'h00;
        checks++;
        if (m_valid !== 1'b1 || m_coarse !== 16'd37 || m_start_fine !== 8'h12
            || m_stop_fine !== 8'hA5 || m_timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: valid=%b coarse=%0d sf=%h pf=%h to=%b required 1 37 12 a5 0",
                     m_valid, m_coarse, m_start_fine, m_stop_fine, m_timeout);
        end
        do_handshake;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_coarse !== 16'd37) begin
            failures++;
            $display("FAIL basic_after_hs: valid=%b busy=%b coarse=%0d required 0 0 37",
                     m_valid, busy, m_coarse);
        end
    endtask

    task automatic test_timeout;
        do_arm_start(8'h5C);
        repeat (999) tick;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b1 || hit_gate !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: valid=%b busy=%b gate=%b required 0 1 1", m_valid, busy, hit_gate);
        end
        tick;
        checks++;
        if (m_valid !== 1'b1 || m_coarse !== 16'd1000 || m_timeout !== 1'b1
            || m_stop_fine !== 8'h00 || m_start_fine !== 8'h5C) begin
            failures++;
            $display("FAIL timeout_result: valid=%b coarse=%0d to=%b pf=%h sf=%h required 1 1000 1 00 5c",
                     m_valid, m_coarse, m_timeout, m_stop_fine, m_start_fine);
        end
        do_handshake;
        do_arm_start(8'h6D);
        repeat (999) tick;
        stop_valid = 1'b1;
        stop_fine = 8'h77;
        tick;
        stop_valid = 1'b0;
        stop_fine = 8'h00;
        checks++;
        if (m_valid !== 1'b1 || m_coarse !== 16'd1000 || m_timeout !== 1'b0
            || m_stop_fine !== 8'h77 || m_start_fine !== 8'h6D) begin
            failures++;
            $display("FAIL timeout_stop_wins: valid=%b coarse=%0d to=%b pf=%h sf=%h required 1 1000 0 77 6d",
                     m_valid, m_coarse, m_timeout, m_stop_fine, m_start_fine);
        end
        do_handshake;
    endtask

    task automatic test_stop_first;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        stop_valid = 1'b1;
        stop_fine = 8'h99;
        tick;
        stop_valid = 1'b0;
        stop_fine = 8'h00;
        tick;
        checks++;
        if ({hit_gate, busy, m_valid} !== 3'b110) begin
            failures++;
            $display("FAIL stop_first_ignored: gate/busy/valid=%b required 110", {hit_gate, busy, m_valid});
        end
        start_valid = 1'b1;
        start_fine = 8'h21;
        stop_valid = 1'b1;
        stop_fine = 8'h43;
        tick;
        start_valid = 1'b0;
        stop_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_coarse !== 16'd0 || m_start_fine !== 8'h21
            || m_stop_fine !== 8'h43 || m_timeout !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle: valid=%b coarse=%0d sf=%h pf=%h to=%b required 1 0 21 43 0",
                     m_valid, m_coarse, m_start_fine, m_stop_fine, m_timeout);
        end
        do_handshake;
    endtask

    task automatic test_back_to_back;
        do_arm_start(8'h01);
        repeat (4) tick;
        stop_valid = 1'b1;
        stop_fine = 8'h02;
        tick;
        stop_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stop_valid = i[0];
            start_valid = ~i[0];
            stop_fine = 8'hFF;
            start_fine = 8'hEE;
            abort = (i == 7);
            tick;
            checks++;
            if (m_valid !== 1'b1 || hit_gate !== 1'b0 || m_coarse !== 16'd5
                || m_start_fine !== 8'h01 || m_stop_fine !== 8'h02 || m_timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b gate=%b coarse=%0d sf=%h pf=%h to=%b required 1 0 5 01 02 0",
                         i, m_valid, hit_gate, m_coarse, m_start_fine, m_stop_fine, m_timeout);
            end
        end
        stop_valid = 1'b0;
        start_valid = 1'b0;
        abort = 1'b0;
        m_ready = 1'b1;
        arm = 1'b1;
        tick;
        m_ready = 1'b0;
        arm = 1'b0;
        checks++;
        if ({hit_gate, busy, m_valid} !== 3'b110) begin
            failures++;
            $display("FAIL hs_with_arm: gate/busy/valid=%b required 110", {hit_gate, busy, m_valid});
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
    endtask

    task automatic test_abort;
        do_arm_start(8'h3C);
        repeat (10) tick;
        abort = 1'b1;
        stop_valid = 1'b1;
        stop_fine = 8'h4D;
        tick;
        abort = 1'b0;
        stop_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || hit_gate !== 1'b0) begin
            failures++;
            $display("FAIL abort_run: busy=%b valid=%b gate=%b required 0 0 0", busy, m_valid, hit_gate);
        end
        repeat (3) tick;
        checks++;
        if (m_valid !== 1'b0 || m_coarse !== 16'd5 || m_start_fine !== 8'h01 || m_stop_fine !== 8'h02) begin
            failures++;
            $display("FAIL abort_keeps_last: valid=%b coarse=%0d sf=%h pf=%h required 0 5 01 02",
                     m_valid, m_coarse, m_start_fine, m_stop_fine);
        end
    endtask

`ifdef TDC_HIT_STATS_EN
    task automatic test_stats;
        checks++;
        if (stat_meas !== 16'd4 || stat_timeouts !== 16'd1) begin
            failures++;
            $display("FAIL stats: meas=%0d timeouts=%0d required 4 1", stat_meas, stat_timeouts);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_timeout;
        test_stop_first;
        test_back_to_back;
        test_abort;
`ifdef TDC_HIT_STATS_EN
        test_stats;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
